// File: rtl/fm_pingpong_buf_bank.sv
// fm_pingpong_buf_bank: ring of NBANK buffer banks per channel, used as a FIFO of banks.
// The loader fills the bank at wr_ptr while the reader drains the bank at rd_ptr.
//
// Handshake: ld_ready=1 means a free bank is open for filling. Writes and an ld_done
// pulse are accepted only while ld_ready=1, and ld_done then hands the fill bank to the
// reader. rd_valid=1 means a filled bank is open for draining. Reads and an rd_done
// pulse are accepted only while rd_valid=1, and rd_done then returns the bank to the
// loader. Any strobe that arrives without its ready/valid is dropped, and it sets the
// sticky error flag on that side.
module fm_pingpong_buf_bank #(
    parameter int CH    = 4,
    parameter int WIDTH = 72,
    parameter int DEPTH = 512,
    parameter int NBANK = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int BW   = $clog2(NBANK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       ld_wr_en,
    input  logic [CH*AW-1:0]    ld_wr_addr,
    input  logic [CH*WIDTH-1:0] ld_din,
    input  logic                ld_done,
    output logic                ld_ready,
    input  logic [CH-1:0]       rd_en,
    input  logic [CH*AW-1:0]    rd_addr,
    output logic [CH*WIDTH-1:0] rd_dout,
    output logic [CH-1:0]       rd_dout_valid,
    output logic                rd_valid,
    input  logic                rd_done,
    output logic [BW:0]         occupancy,
    output logic                err_overrun,
    output logic                err_underrun
);

    localparam logic [BW:0] OCC_FULL = (BW+1)'(NBANK);

    logic [BW-1:0] wr_ptr;
    logic [BW-1:0] rd_ptr;
    logic [BW:0]   occ;
    logic          ld_acc;
    logic          rd_acc;

    // Availability depends only on registered occupancy, so no input reaches these outputs.
    assign ld_ready  = (occ < OCC_FULL);
    assign rd_valid  = (occ != '0);
    assign occupancy = occ;
    assign ld_acc    = ld_done && ld_ready;
    assign rd_acc    = rd_done && rd_valid;

    // Bank ring pointers, occupancy and sticky error flags.
    // NBANK is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            if (ld_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ld_acc && !rd_acc) begin
                occ <= occ + 1'b1;
            end else if (rd_acc && !ld_acc) begin
                occ <= occ - 1'b1;
            end
            if (!ld_ready && ((|ld_wr_en) || ld_done)) begin
                err_overrun <= 1'b1;
            end
            if (!rd_valid && ((|rd_en) || rd_done)) begin
                err_underrun <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [WIDTH-1:0] mem [NBANK*DEPTH];
        logic [WIDTH-1:0] dout_q;
        logic             dv_q;
        logic [AW-1:0]    wa;
        logic [AW-1:0]    ra;

        assign wa = ld_wr_addr[c*AW +: AW];
        assign ra = rd_addr[c*AW +: AW];

        // Fill-side write into the bank at wr_ptr. A write that coincides with ld_done
        // still lands in the old bank, because wr_ptr has not moved yet.
        always_ff @(posedge clk) begin
            if (!rst && ld_wr_en[c] && ld_ready) begin
                mem[{wr_ptr, wa}] <= ld_din[c*WIDTH +: WIDTH];
            end
        end

        // Drain-side registered read from the bank at rd_ptr.
        // The data is held when no read is accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (rd_en[c] && rd_valid) begin
                dout_q <= mem[{rd_ptr, ra}];
                dv_q   <= 1'b1;
            end else begin
                dv_q   <= 1'b0;
            end
        end

        assign rd_dout[c*WIDTH +: WIDTH] = dout_q;
        assign rd_dout_valid[c]          = dv_q;
    end

endmodule

// File: tb/tb_fm_pingpong_buf_bank.sv
// Bench for fm_pingpong_buf_bank. One instance uses NBANK=2 and one uses NBANK=4.
// Both instances share the same inputs, and sel chooses which instance's outputs are
// checked in the current phase. A bank-FIFO reference model predicts every output.
module tb_fm_pingpong_buf_bank;

    localparam int CH    = 4;
    localparam int W     = 72;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    // ---------------- clock / shared stimulus ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [CH-1:0]     ld_wr_en;
    logic [CH-1:0]     rd_en;
    logic              ld_done;
    logic              rd_done;
    logic [CH*AW-1:0]  ld_wr_addr;
    logic [CH*AW-1:0]  rd_addr;
    logic [CH*W-1:0]   ld_din;
    logic [AW-1:0]     wa [CH];
    logic [AW-1:0]     ra [CH];
    logic [W-1:0]      wd [CH];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            ld_wr_addr[c*AW +: AW] = wa[c];
            rd_addr[c*AW +: AW]    = ra[c];
            ld_din[c*W +: W]       = wd[c];
        end
    end

    // ---------------- DUTs ----------------
    logic             a_ldr, a_rdv, a_ov, a_un;
    logic [CH-1:0]    a_dv;
    logic [CH*W-1:0]  a_dout;
    logic [1:0]       a_occ;
    logic             b_ldr, b_rdv, b_ov, b_un;
    logic [CH-1:0]    b_dv;
    logic [CH*W-1:0]  b_dout;
    logic [2:0]       b_occ;

    fm_pingpong_buf_bank #(.CH(CH), .WIDTH(W), .DEPTH(DEPTH), .NBANK(2)) dut2 (
        .clk(clk), .rst(rst), .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_din(ld_din),
        .ld_done(ld_done), .ld_ready(a_ldr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(a_dout), .rd_dout_valid(a_dv), .rd_valid(a_rdv), .rd_done(rd_done),
        .occupancy(a_occ), .err_overrun(a_ov), .err_underrun(a_un)
    );

    fm_pingpong_buf_bank #(.CH(CH), .WIDTH(W), .DEPTH(DEPTH), .NBANK(4)) dut4 (
        .clk(clk), .rst(rst), .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_din(ld_din),
        .ld_done(ld_done), .ld_ready(b_ldr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(b_dout), .rd_dout_valid(b_dv), .rd_valid(b_rdv), .rd_done(rd_done),
        .occupancy(b_occ), .err_overrun(b_ov), .err_underrun(b_un)
    );

    logic             sel;
    logic             o_ldr, o_rdv, o_ov, o_un;
    logic [CH-1:0]    o_dv;
    logic [CH*W-1:0]  o_dout;
    int               o_occ;

    always_comb begin
        if (sel) begin
            o_ldr = b_ldr; o_rdv = b_rdv; o_ov = b_ov; o_un = b_un;
            o_dv = b_dv; o_dout = b_dout; o_occ = int'(b_occ);
        end else begin
            o_ldr = a_ldr; o_rdv = a_rdv; o_ov = a_ov; o_un = a_un;
            o_dv = a_dv; o_dout = a_dout; o_occ = int'(a_occ);
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model: FIFO of filled bank ids ----------------
    int          nb;
    int          full_q[$];
    int          fill_bank;
    bit          m_ov, m_un;
    bit          e_dv [CH];
    bit          e_known [CH];
    logic [W-1:0] e_dout [CH];
    logic [W-1:0] mm [int];

    function automatic int key(input int c, input int b, input int a);
        return (c * 4 + b) * DEPTH + a;
    endfunction

    function automatic logic [W-1:0] pat(input int tag, input int c, input int a);
        return W'(tag * 100000 + c * 1000 + a);
    endfunction

    task automatic idle();
        rst = 1'b0; ld_wr_en = '0; rd_en = '0; ld_done = 1'b0; rd_done = 1'b0;
        for (int c = 0; c < CH; c++) begin
            wa[c] = '0; ra[c] = '0; wd[c] = '0;
        end
    endtask

    // Update the model with the current inputs, clock once, then compare every output.
    task automatic step();
        bit ready, valid;
        int db;
        ready = full_q.size() < nb;
        valid = full_q.size() > 0;
        db    = valid ? full_q[0] : 0;
        if (rst) begin
            full_q.delete();
            fill_bank = 0; m_ov = 0; m_un = 0;
            for (int c = 0; c < CH; c++) begin
                e_dv[c] = 0; e_dout[c] = '0; e_known[c] = 1;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (ld_wr_en[c]) begin
                    if (ready) mm[key(c, fill_bank, int'(wa[c]))] = wd[c];
                    else m_ov = 1;
                end
            end
            if (ld_done && !ready) m_ov = 1;
            for (int c = 0; c < CH; c++) begin
                if (rd_en[c] && valid) begin
                    e_dv[c] = 1;
                    if (mm.exists(key(c, db, int'(ra[c])))) begin
                        e_dout[c] = mm[key(c, db, int'(ra[c]))]; e_known[c] = 1;
                    end else begin
                        e_known[c] = 0;
                    end
                end else begin
                    e_dv[c] = 0;
                end
                if (rd_en[c] && !valid) m_un = 1;
            end
            if (rd_done) begin
                if (valid) void'(full_q.pop_front());
                else m_un = 1;
            end
            if (ld_done && ready) begin
                full_q.push_back(fill_bank);
                fill_bank = (fill_bank + 1) % nb;
            end
        end
        @(posedge clk);
        #1;
        chk("ld_ready", W'(o_ldr), W'(full_q.size() < nb));
        chk("rd_valid", W'(o_rdv), W'(full_q.size() > 0));
        chk("occupancy", W'(o_occ), W'(full_q.size()));
        chk("err_overrun", W'(o_ov), W'(m_ov));
        chk("err_underrun", W'(o_un), W'(m_un));
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rd_dout_valid[%0d]", c), W'(o_dv[c]), W'(e_dv[c]));
            if (e_known[c]) chk($sformatf("rd_dout[%0d]", c), o_dout[c*W +: W], e_dout[c]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        idle(); rst = 1'b1; step(); idle();
    endtask

    task automatic fill_words(input int tag);
        for (int a = 0; a < DEPTH; a++) begin
            ld_wr_en = '1;
            for (int c = 0; c < CH; c++) begin
                wa[c] = AW'(a); wd[c] = pat(tag, c, a);
            end
            step();
        end
        idle();
    endtask

    task automatic fill(input int tag);
        fill_words(tag);
        ld_done = 1'b1; step(); idle();
    endtask

    task automatic drain(input int tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = '1;
            for (int c = 0; c < CH; c++) ra[c] = AW'(a);
            step();
            for (int c = 0; c < CH; c++)
                chk($sformatf("drain tag%0d ch%0d a%0d", tag, c, a), o_dout[c*W +: W], pat(tag, c, a));
        end
        idle();
        rd_done = 1'b1; step(); idle();
    endtask

    // ---------------- directed vector table (NBANK=2) ----------------
    typedef struct {
        bit rst; logic [3:0] wen; int waddr; int wtag; bit ldd;
        logic [3:0] ren; int raddr; bit rdd;
        int x_occ; bit x_ldr; bit x_rdv; bit x_ov; bit x_un; logic [3:0] x_dv; int x_d2;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [3:0] wen, input int waddr, input int wtag,
                                input bit ldd, input logic [3:0] ren, input int raddr, input bit rdd,
                                input int x_occ, input bit x_ldr, input bit x_rdv, input bit x_ov,
                                input bit x_un, input logic [3:0] x_dv, input int x_d2);
        vec_t v;
        v.rst = r; v.wen = wen; v.waddr = waddr; v.wtag = wtag; v.ldd = ldd;
        v.ren = ren; v.raddr = raddr; v.rdd = rdd; v.x_occ = x_occ; v.x_ldr = x_ldr;
        v.x_rdv = x_rdv; v.x_ov = x_ov; v.x_un = x_un; v.x_dv = x_dv; v.x_d2 = x_d2;
        return v;
    endfunction

    vec_t vt [21];

    initial begin
        //        rst wen   wa tg ldd ren  ra rdd  occ ldr rdv ov un  dv    d2
        vt[0]  = mk(1, 4'h0, 0, 0, 0, 4'h0, 0, 0,  0, 1, 0, 0, 0, 4'h0, 0);
        vt[1]  = mk(0, 4'h0, 0, 0, 0, 4'h0, 0, 0,  0, 1, 0, 0, 0, 4'h0, 0);
        vt[2]  = mk(0, 4'h0, 0, 0, 0, 4'hF, 0, 1,  0, 1, 0, 0, 1, 4'h0, 0);
        vt[3]  = mk(1, 4'h0, 0, 0, 0, 4'h0, 0, 0,  0, 1, 0, 0, 0, 4'h0, 0);
        vt[4]  = mk(0, 4'hF, 3, 1, 0, 4'h0, 0, 0,  0, 1, 0, 0, 0, 4'h0, 0);
        vt[5]  = mk(0, 4'hF, 4, 1, 1, 4'h0, 0, 0,  1, 1, 1, 0, 0, 4'h0, 0);
        vt[6]  = mk(0, 4'h0, 0, 0, 0, 4'h4, 3, 0,  1, 1, 1, 0, 0, 4'h4, 12003);
        vt[7]  = mk(0, 4'hF, 3, 2, 0, 4'h4, 4, 0,  1, 1, 1, 0, 0, 4'h4, 12004);
        vt[8]  = mk(0, 4'h0, 0, 0, 1, 4'h0, 0, 0,  2, 0, 1, 0, 0, 4'h0, 0);
        vt[9]  = mk(0, 4'h1, 3, 9, 0, 4'h0, 0, 0,  2, 0, 1, 1, 0, 4'h0, 0);
        vt[10] = mk(0, 4'h0, 0, 0, 0, 4'h4, 3, 0,  2, 0, 1, 1, 0, 4'h4, 12003);
        vt[11] = mk(0, 4'h0, 0, 0, 0, 4'h4, 4, 1,  1, 1, 1, 1, 0, 4'h4, 12004);
        vt[12] = mk(0, 4'h0, 0, 0, 0, 4'h4, 3, 0,  1, 1, 1, 1, 0, 4'h4, 22003);
        vt[13] = mk(0, 4'hF, 3, 3, 0, 4'h0, 0, 0,  1, 1, 1, 1, 0, 4'h0, 0);
        vt[14] = mk(0, 4'h0, 0, 0, 1, 4'h0, 0, 1,  1, 1, 1, 1, 0, 4'h0, 0);
        vt[15] = mk(0, 4'h0, 0, 0, 0, 4'h4, 3, 0,  1, 1, 1, 1, 0, 4'h4, 32003);
        vt[16] = mk(0, 4'h0, 0, 0, 1, 4'h0, 0, 0,  2, 0, 1, 1, 0, 4'h0, 0);
        vt[17] = mk(0, 4'h0, 0, 0, 0, 4'h0, 0, 1,  1, 1, 1, 1, 0, 4'h0, 0);
        vt[18] = mk(0, 4'h0, 0, 0, 1, 4'h0, 0, 0,  2, 0, 1, 1, 0, 4'h0, 0);
        vt[19] = mk(0, 4'h0, 0, 0, 1, 4'h0, 0, 0,  2, 0, 1, 1, 0, 4'h0, 0);
        vt[20] = mk(1, 4'h0, 0, 0, 0, 4'h0, 0, 0,  0, 1, 0, 0, 0, 4'h0, 0);

        // ---- phase A: NBANK=2 ----
        sel = 1'b0; nb = 2; mm.delete();
        full_q.delete(); fill_bank = 0; m_ov = 0; m_un = 0;
        for (int c = 0; c < CH; c++) begin
            e_dv[c] = 0; e_known[c] = 0; e_dout[c] = '0;
        end
        idle();

        for (int i = 0; i < 21; i++) begin
            idle();
            rst = vt[i].rst; ld_wr_en = vt[i].wen; ld_done = vt[i].ldd;
            rd_en = vt[i].ren; rd_done = vt[i].rdd;
            for (int c = 0; c < CH; c++) begin
                wa[c] = AW'(vt[i].waddr);
                wd[c] = W'(vt[i].wtag * 10000 + c * 1000 + vt[i].waddr);
                ra[c] = AW'(vt[i].raddr);
            end
            step();
            chk($sformatf("vec%0d occupancy", i), W'(o_occ), W'(vt[i].x_occ));
            chk($sformatf("vec%0d ld_ready", i), W'(o_ldr), W'(vt[i].x_ldr));
            chk($sformatf("vec%0d rd_valid", i), W'(o_rdv), W'(vt[i].x_rdv));
            chk($sformatf("vec%0d err_overrun", i), W'(o_ov), W'(vt[i].x_ov));
            chk($sformatf("vec%0d err_underrun", i), W'(o_un), W'(vt[i].x_un));
            chk($sformatf("vec%0d rd_dout_valid", i), W'(o_dv), W'(vt[i].x_dv));
            if (vt[i].x_dv[2]) chk($sformatf("vec%0d rd_dout[2]", i), o_dout[2*W +: W], W'(vt[i].x_d2));
        end
        idle();

        // Full fill of bank 0, then a single read of addr 5 on ch2.
        reset_dut();
        fill(0);
        chk("fill0 rd_valid", W'(o_rdv), W'(1));
        chk("fill0 occupancy", W'(o_occ), W'(1));
        rd_en = 4'b0100; ra[2] = AW'(5); step(); idle();
        chk("ch2 addr5 valid", W'(o_dv), W'(4'b0100));
        chk("ch2 addr5 data", o_dout[2*W +: W], W'(2005));

        // Both banks full: a further write is dropped and bank 0 stays intact.
        fill(1);
        chk("full ld_ready", W'(o_ldr), W'(0));
        chk("full occupancy", W'(o_occ), W'(2));
        ld_wr_en = '1;
        for (int c = 0; c < CH; c++) begin
            wa[c] = '0; wd[c] = W'(77777);
        end
        step(); idle();
        chk("overrun flag", W'(o_ov), W'(1));
        rd_en = '1; step(); idle();
        for (int c = 0; c < CH; c++)
            chk($sformatf("bank0 addr0 ch%0d", c), o_dout[c*W +: W], W'(c * 1000));

        // Bank 0 full: ld_done for bank 1 and rd_done for bank 0 in the same cycle.
        reset_dut();
        fill(0);
        fill_words(1);
        ld_done = 1'b1; rd_done = 1'b1; step(); idle();
        chk("swap occupancy", W'(o_occ), W'(1));
        rd_en = '1;
        for (int c = 0; c < CH; c++) ra[c] = AW'(7);
        step(); idle();
        for (int c = 0; c < CH; c++)
            chk($sformatf("swap bank1 ch%0d", c), o_dout[c*W +: W], pat(1, c, 7));

        // ---- phase B: NBANK=4, ten fills drained in order across pointer wraps ----
        sel = 1'b1; nb = 4; mm.delete();
        reset_dut();
        begin
            int d;
            d = 0;
            for (int k = 0; k < 10; k++) begin
                fill(k);
                if (k >= 3) begin
                    if (k == 3) chk("nbank4 full ld_ready", W'(o_ldr), W'(0));
                    drain(d); d++;
                end
            end
            while (d < 10) begin
                drain(d); d++;
            end
        end

        // ---- randomized traffic on both ring sizes ----
        for (int p = 0; p < 2; p++) begin
            sel = p[0]; nb = (p == 0) ? 2 : 4; mm.delete();
            reset_dut();
            for (int i = 0; i < 1500; i++) begin
                rst      = ($urandom_range(0, 299) == 0);
                ld_wr_en = CH'($urandom());
                rd_en    = CH'($urandom());
                ld_done  = ($urandom_range(0, 15) == 0);
                rd_done  = ($urandom_range(0, 15) == 0);
                for (int c = 0; c < CH; c++) begin
                    wa[c] = AW'($urandom_range(0, 7));
                    ra[c] = AW'($urandom_range(0, 7));
                    wd[c] = W'({$urandom(), $urandom(), $urandom()});
                end
                step();
            end
            idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
